// File: rtl/tiny_dnn_core_fx.sv
// Fixed-point MAC core: N_BANK weight banks, 3-stage read/operand/accumulate pipeline, sum chain.
// Define TINY_DNN_CORE_SAT_EN for clamping accumulation with a sticky sat flag (default: wrap).
module tiny_dnn_core_fx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned F_SIZE = 1024,
    parameter int unsigned N_BANK = 2,
    parameter int unsigned AW     = $clog2(F_SIZE) + $clog2(N_BANK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              write,
    input  logic              bwrite,
    input  logic              exec,
    input  logic              bias,
    input  logic              outr,
    input  logic              update,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] wd,
    input  logic [ACC_W-1:0]  sum_in,
    output logic [ACC_W-1:0]  sum,
    output logic              busy,
    output logic              sat
);
    localparam int unsigned IW = $clog2(F_SIZE);
    localparam int unsigned BW = $clog2(N_BANK);
    localparam int unsigned PW = 2 * DATA_W;
    localparam logic [IW-1:0] BIAS_IDX = IW'(F_SIZE - 1);

    typedef struct packed {
        logic init;
        logic exec;
        logic bias;
    } op_t;

    logic signed [DATA_W-1:0] mem [N_BANK*F_SIZE];

    logic [AW-1:0] rd_addr, wr_addr;
    logic          collide, rd_en;

    op_t                      op1_q, op1_d, op2_q, op2_d;
    logic signed [DATA_W-1:0] w_q, w_d, w1_q, w1_d, d1_q, d1_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, shreg_q, shreg_d;
    logic signed [PW-1:0]     prod, prod_sh;
    logic signed [ACC_W-1:0]  addend, acc_sum;

    // A same-bank write owns the bank port this cycle; the read is dropped and w keeps its value.
    always_comb begin
        wr_addr = {wa[AW-1 -: BW], bwrite ? BIAS_IDX : wa[IW-1:0]};
        rd_addr = {ra[AW-1 -: BW], bias ? BIAS_IDX : ra[IW-1:0]};
        collide = write && (wa[AW-1 -: BW] == ra[AW-1 -: BW]);
        rd_en   = (exec || bias) && !collide;
    end

    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_addr] <= wd;
        end
    end

    always_comb begin
        prod    = PW'(w1_q) * PW'(d1_q);
        prod_sh = prod >>> FRAC_W;
        addend  = op2_q.exec ? ACC_W'(prod_sh) : ACC_W'(w1_q);
    end

`ifdef TINY_DNN_CORE_SAT_EN
    logic signed [ACC_W:0] sum_wide;
    logic                  ovf, sat_q, sat_d;

    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {addend[ACC_W-1], addend};
        ovf      = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (!ovf) begin
            acc_sum = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            acc_sum = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_sum = {1'b0, {(ACC_W-1){1'b1}}};
        end
        sat_d = sat_q;
        if (op2_q.init) begin
            sat_d = 1'b0;
        end else if ((op2_q.exec || op2_q.bias) && ovf) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    always_comb acc_sum = acc_q + addend;
    assign sat = 1'b0;
`endif

    always_comb begin
        op1_d   = '{init: init, exec: exec, bias: bias};
        op2_d   = op1_q;
        w_d     = rd_en ? mem[rd_addr] : w_q;
        w1_d    = w1_q;
        d1_d    = d1_q;
        if (op1_q.init || op1_q.exec || op1_q.bias) begin
            w1_d = w_q;
            d1_d = d;
        end
        shreg_d = outr ? sum_in : shreg_q;
        acc_d   = acc_q;
        if (op2_q.init) begin
            acc_d = '0;
        end else if (op2_q.exec || op2_q.bias) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q   <= '0;
            op2_q   <= '0;
            w_q     <= '0;
            w1_q    <= '0;
            d1_q    <= '0;
            acc_q   <= '0;
            shreg_q <= '0;
        end else begin
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            w_q     <= w_d;
            w1_q    <= w1_d;
            d1_q    <= d1_d;
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
        end
    end

    assign sum  = update ? acc_q : shreg_q;
    assign busy = (op1_q.init || op1_q.exec || op1_q.bias) ||
                  (op2_q.init || op2_q.exec || op2_q.bias);

endmodule

// File: tb/tb_tiny_dnn_core_fx.sv
// Directed bench for tiny_dnn_core_fx: table-driven MAC vectors plus pipeline corner sequences.
module tb_tiny_dnn_core_fx;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned F_SIZE = 1024;
    localparam int unsigned N_BANK = 2;
    localparam int unsigned AW     = 11;

`ifdef TINY_DNN_CORE_SAT_EN
    localparam logic [31:0] SAT_SUM = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_FLG = 32'd1;
`else
    localparam logic [31:0] SAT_SUM = 32'h81FD_F800;
    localparam logic [31:0] SAT_FLG = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init = 1'b0, write = 1'b0, bwrite = 1'b0, exec = 1'b0, bias = 1'b0;
    logic              outr = 1'b0, update = 1'b1;
    logic [AW-1:0]     ra = '0, wa = '0;
    logic [DATA_W-1:0] d = '0, wd = '0;
    logic [ACC_W-1:0]  sum_in = '0;
    logic [ACC_W-1:0]  sum;
    logic              busy, sat;

    int checks = 0;
    int errors = 0;

    tiny_dnn_core_fx #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W),
        .F_SIZE(F_SIZE), .N_BANK(N_BANK), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .write(write), .bwrite(bwrite),
        .exec(exec), .bias(bias), .outr(outr), .update(update), .ra(ra), .wa(wa),
        .d(d), .wd(wd), .sum_in(sum_in), .sum(sum), .busy(busy), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic [15:0] w;
        logic [15:0] dv;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[7];

    function automatic logic [AW-1:0] addr(input int unsigned b, input int unsigned i);
        return AW'(b * F_SIZE + i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] v, input logic bw);
        write = 1'b1; bwrite = bw; wa = a; wd = v;
        tick();
        write = 1'b0; bwrite = 1'b0;
    endtask

    // init, then one exec with d one cycle later; returns in the cycle the result is visible
    task automatic run_mac(input logic [AW-1:0] a, input logic [15:0] dv);
        init = 1'b1;
        tick();
        init = 1'b0; exec = 1'b1; ra = a;
        tick();
        exec = 1'b0; d = dv;
        tick();
        d = '0;
        tick();
    endtask

    initial begin
        tv[0] = '{16, 16'h0200, 16'h0180, 32'h0000_0300};
        tv[1] = '{17, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
        tv[2] = '{18, 16'h0100, 16'hFF00, 32'hFFFF_FF00};
        tv[3] = '{19, 16'h0080, 16'h0080, 32'h0000_0040};
        tv[4] = '{20, 16'h7FFF, 16'h7FFF, 32'h003F_FF00};
        tv[5] = '{21, 16'h8000, 16'h8000, 32'h0040_0000};
        tv[6] = '{22, 16'hFFFE, 16'h0003, 32'hFFFF_FFFF};

        repeat (2) tick();
        chk("reset_sum_acc", sum, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_sat", 32'(sat), 32'h0);
        update = 1'b0; #1;
        chk("reset_sum_shreg", sum, 32'h0);
        update = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            wr(addr(0, tv[i].idx), tv[i].w, 1'b0);
            run_mac(addr(0, tv[i].idx), tv[i].dv);
            chk($sformatf("mac_vec%0d", i), sum, tv[i].exp);
            chk($sformatf("mac_vec%0d_busy", i), 32'(busy), 32'h0);
        end

        // Bias word written with a non-top index, which bwrite must force to F_SIZE-1
        wr(addr(1, 3), 16'hFF80, 1'b1);
        for (int i = 0; i < 4; i++) wr(addr(1, i), 16'h0100, 1'b0);
        init = 1'b1;
        tick();
        init = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exec = (k < 4);
            bias = (k == 4);
            ra   = addr(1, k);
            d    = (k >= 1) ? 16'h0100 : 16'h0000;
            tick();
        end
        exec = 1'b0; bias = 1'b0; d = '0;
        chk("b2b_busy_1", 32'(busy), 32'h1);
        tick();
        chk("b2b_busy_2", 32'(busy), 32'h1);
        tick();
        chk("b2b_busy_off", 32'(busy), 32'h0);
        chk("b2b_bias_sum", sum, 32'h0000_0380);

        // Same-bank collision: second exec must reuse w from the first (3.0)
        wr(addr(0, 7), 16'h0100, 1'b0);
        wr(addr(0, 8), 16'h0300, 1'b0);
        init = 1'b1;
        tick();
        init = 1'b0; exec = 1'b1; ra = addr(0, 8);
        tick();
        ra = addr(0, 7); d = 16'h0100; write = 1'b1; wa = addr(0, 7); wd = 16'h0500;
        tick();
        exec = 1'b0; write = 1'b0; d = 16'h0100;
        tick();
        d = '0;
        tick();
        chk("collide_stale_w", sum, 32'h0000_0600);
        run_mac(addr(0, 7), 16'h0100);
        chk("collide_write_landed", sum, 32'h0000_0500);

        // Different banks: read bank0 while writing bank1
        wr(addr(0, 9), 16'h0200, 1'b0);
        init = 1'b1;
        tick();
        init = 1'b0; exec = 1'b1; ra = addr(0, 9);
        write = 1'b1; wa = addr(1, 9); wd = 16'h0700;
        tick();
        exec = 1'b0; write = 1'b0; d = 16'h0100;
        tick();
        d = '0;
        tick();
        chk("parallel_read", sum, 32'h0000_0200);
        run_mac(addr(1, 9), 16'h0100);
        chk("parallel_write", sum, 32'h0000_0700);

        outr = 1'b1; sum_in = 32'h1234_5678; update = 1'b0;
        tick();
        outr = 1'b0; sum_in = 32'hDEAD_BEEF;
        chk("chain_shreg", sum, 32'h1234_5678);
        tick();
        chk("chain_shreg_hold", sum, 32'h1234_5678);
        update = 1'b1; #1;
        chk("chain_update_acc", sum, 32'h0000_0700);

        // 520 MACs of 0x3FFF00 each overflow ACC_W on the 513th
        wr(addr(0, 100), 16'h7FFF, 1'b0);
        init = 1'b1;
        tick();
        init = 1'b0; exec = 1'b1; ra = addr(0, 100); d = 16'h7FFF;
        repeat (520) tick();
        exec = 1'b0;
        tick();
        tick();
        d = '0;
        chk("sat_sum", sum, SAT_SUM);
        chk("sat_flag", 32'(sat), SAT_FLG);
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        tick();
        chk("sat_cleared_by_init", 32'(sat), 32'h0);
        chk("sat_acc_cleared", sum, 32'h0);

        exec = 1'b1; ra = addr(0, 16); d = 16'h0180;
        tick();
        tick();
        chk("midop_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midop_reset_sum", sum, 32'h0);
        chk("midop_reset_busy", 32'(busy), 32'h0);
        exec = 1'b0; d = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_mac(addr(0, 16), 16'h0180);
        chk("post_reset_mac", sum, 32'h0000_0300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
